// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multicycle mult/div unit.
package multdiv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MULT,
    DIV,
    FIX,
    DONE
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int MD_WIDTH = 32;
  localparam int CNT_W    = $clog2(MD_WIDTH + 1);

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/multdiv_div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract, restore.
module multdiv_div_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvsr,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0]   w_sh;
  logic [WIDTH+1:0] w_diff;

  assign w_sh   = {i_rem, i_quo[WIDTH-1]};
  assign w_diff = {1'b0, w_sh} - {2'b00, i_dvsr};

  // Negative trial result means restore: keep the shifted remainder.
  always_comb begin
    if (w_diff[WIDTH+1]) begin
      o_rem = w_sh[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b0};
    end else begin
      o_rem = w_diff[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed Booth multiplier / restoring divider feeding Hi/Lo.
// Optional multu/divu support via `define MULTDIV_UNSIGNED_EN.
module mult_div_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Op,
`ifdef MULTDIV_UNSIGNED_EN
  input  logic             Unsigned,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int CW = cnt_w(WIDTH);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH:0]   r_m;
  logic [WIDTH-1:0] r_q;
  logic             r_qm1;
  logic [WIDTH-1:0] r_rem;
  logic             r_sa;
  logic             r_sb;
  logic             r_uns;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;

  logic             w_uns;
  logic             w_sx;
  logic [WIDTH-1:0] w_absa;
  logic [WIDTH-1:0] w_absb;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_badd;
  logic [WIDTH-1:0] w_dr;
  logic [WIDTH-1:0] w_dq;

`ifdef MULTDIV_UNSIGNED_EN
  assign w_uns = Unsigned;
`else
  assign w_uns = 1'b0;
`endif

  assign w_sx   = ~w_uns;
  assign w_absa = (w_sx & A[WIDTH-1]) ? -A : A;
  assign w_absb = (w_sx & B[WIDTH-1]) ? -B : B;

  always_comb begin
    w_sum = r_acc;
    unique case ({r_q[0], r_qm1})
      2'b01:   w_sum = r_acc + r_m;
      2'b10:   w_sum = r_acc - r_m;
      default: w_sum = r_acc;
    endcase
  end

  // Extra unsigned step: Booth pair {0, b[W-1]} adds M at weight 2^W.
  assign w_badd = r_acc + (r_qm1 ? r_m : '0);

  multdiv_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_quo  (r_q),
    .i_dvsr (r_m[WIDTH-1:0]),
    .o_rem  (w_dr),
    .o_quo  (w_dq)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_qm1   <= 1'b0;
      r_rem   <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_uns   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (Start) begin
            r_busy <= 1'b1;
            r_cnt  <= CW'(WIDTH);
            r_uns  <= w_uns;
            if (Op == OP_MULT) begin
              r_acc   <= '0;
              r_q     <= B;
              r_qm1   <= 1'b0;
              r_m     <= {w_sx & A[WIDTH-1], A};
              r_state <= MULT;
            end else if (B == '0) begin
              r_done  <= 1'b1;
              r_dz    <= 1'b1;
              r_state <= DONE;
            end else begin
              r_rem   <= '0;
              r_q     <= w_absa;
              r_m     <= {1'b0, w_absb};
              r_sa    <= w_sx & A[WIDTH-1];
              r_sb    <= w_sx & B[WIDTH-1];
              r_state <= DIV;
            end
          end
        end
        MULT: begin
          if (r_cnt == '0) begin
            r_hi    <= w_badd[WIDTH-1:0];
            r_lo    <= r_q;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_acc <= {w_sum[WIDTH], w_sum[WIDTH:1]};
            r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
            r_qm1 <= r_q[0];
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1) && !r_uns) begin
              r_hi    <= w_sum[WIDTH:1];
              r_lo    <= {w_sum[0], r_q[WIDTH-1:1]};
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        DIV: begin
          r_rem <= w_dr;
          r_q   <= w_dq;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= FIX;
        end
        FIX: begin
          r_lo    <= (r_sa ^ r_sb) ? -r_q : r_q;
          r_hi    <= r_sa ? -r_rem : r_rem;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Hi      = r_hi;
  assign Lo      = r_lo;
  assign Busy    = r_busy;
  assign Done    = r_done;
  assign DivZero = r_dz;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Sequential signed multiply/divide unit for the multicycle MIPS datapath. It serves mult/div instructions.
- Consumes Start/Op from the control FSM and operands from registers A/B. It returns Done and DivZero to the FSM.
- Results go to architectural Hi/Lo, which are read by mfhi/mflo through the MemToReg mux.
- One iteration per clock. The control FSM waits in a stall state until Done.

Parameters:
- WIDTH, 32, operand width. Hi/Lo are each WIDTH bits; the product is 2*WIDTH bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Start  in  1  begin operation; sampled only in IDLE.
- Op  in  1  0 = mult, 1 = div.
- A  in  WIDTH  multiplicand / dividend (rs).
- B  in  WIDTH  multiplier / divisor (rt).
- Hi  out  WIDTH  mult: product[2W-1:W]; div: remainder.
- Lo  out  WIDTH  mult: product[W-1:0]; div: quotient.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle completion pulse.
- DivZero  out  1  one-cycle pulse coincident with Done when a div had B == 0.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, and takes priority over everything else.
- Reset values: Hi=0, Lo=0, Busy=0, Done=0, DivZero=0, state=IDLE, counter=0, internal accumulators=0.
- Reset mid-operation aborts immediately. Partial results are discarded; no Done is issued.
- States: IDLE, MULT, DIV, FIX, DONE.
- IDLE:
  - Start=1, Op=0: latch A and B, clear the accumulator, counter=WIDTH, go to MULT.
  - Start=1, Op=1, B!=0: latch |A| and |B| plus both sign bits, counter=WIDTH, go to DIV.
  - Start=1, Op=1, B==0: go to DONE with the divzero flag set; no iterations.
- MULT: radix-2 Booth.
  - Each cycle examine {P[0], q-1} and add, subtract or do nothing with the multiplicand into the upper half.
  - Then arithmetic-shift the 2W+1 register right by 1 and decrement the counter.
  - When the counter reaches 1 on an active step, go to DONE.
- DIV: restoring division on magnitudes.
  - Each cycle shift {R,Q} left by 1, then trial-subtract the divisor.
  - Non-negative result: keep it and set Q[0]=1; otherwise restore.
  - Decrement the counter; after WIDTH steps go to FIX.
- FIX: sign correction, truncation toward zero.
  - Quotient is negated if sign(A) xor sign(B).
  - Remainder takes the sign of A.
- DONE:
  - Write Hi/Lo, except on divzero, where Hi/Lo hold their previous values.
  - Assert Done=1 (and DivZero=1 if flagged) for exactly this cycle, then return to IDLE.
- Latency, counted in cycles from the edge that samples Start to Done high:
  - mult: WIDTH+1.
  - div: WIDTH+2.
  - div by zero: 1.
- Start while Busy is ignored; no queuing. Start may be reasserted on the cycle Done is high, but it is only sampled once back in IDLE.
- Hi/Lo are stable between completions. They never show intermediate values.
- Overflow case (-2^(W-1)) / (-1): Lo = 0x80000000 (wrapped), Hi = 0. No flag.
- Arithmetic: all operations are modular in their stated widths. The Booth accumulator is W+1 bits so subtracting -2^(W-1) does not lose the sign.

Optional Feature:
- Macro: MULTDIV_UNSIGNED_EN.
- Defined:
  - Adds input port Unsigned (1 bit), sampled with Start, to support multu/divu.
  - Unsigned=1, mult: the multiplicand is zero-extended to W+1 bits and a final Booth step on the implicit 0 MSB is added, so latency becomes WIDTH+2.
  - Unsigned=1, div: the magnitude and FIX corrections are skipped; latency is unchanged.
- Undefined: the port is absent and all operations are signed.

Decomposition:
- Package multdiv_pkg holds:
  - the state enum (IDLE, MULT, DIV, FIX, DONE);
  - OP_MULT=1'b0 and OP_DIV=1'b1;
  - the counter width constant $clog2(WIDTH+1).
- One natural sub-module: multdiv_div_step, a combinational shift, trial-subtract and restore stage. The FSM and Booth path stay in the top.

Test Plan:
- mult 7 × -3 (0x00000007, 0xFFFFFFFD) -> Done on cycle 33: Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Busy high for cycles 1–33.
- mult 0x7FFFFFFF × 0x7FFFFFFF -> Hi=0x3FFFFFFF, Lo=0x00000001. Also 0x80000000 × 0x80000000 -> Hi=0x40000000, Lo=0.
- div -7 / 2 -> Done on cycle 34: Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Also div 7 / -2 -> Lo=0xFFFFFFFD, Hi=0x00000001.
- div 5 / 0 with Hi/Lo preloaded from a prior mult -> Done=DivZero=1 on cycle 1; Hi/Lo unchanged. Also 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- Start mult, pulse Start again at cycle 5 with other operands -> second Start ignored, first result correct. Then reset at cycle 10 of a new mult -> next cycle Busy=0, Hi=Lo=0, no Done.
